// File: rtl/dmem_responder.sv
// CPU data-memory responder: byte-enabled word RAM plus an MMIO console FIFO and cycle counter.
// Reads are combinational with zero latency; stores commit at the edge; the console drains on valid/ready.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        write_en,
   input  logic        read_en,
   input  logic [3:0]  byte_enable,
   output logic [31:0] read_data,
   output logic [7:0]  console_data,
   output logic        console_valid,
   input  logic        console_ready,
   output logic        bus_error
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   ram [DEPTH_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          bus_error_q;
   logic [31:0]   cycle_q;

   logic          ram_hit, mmio_hit, unmapped;
   logic [AW-1:0] ram_idx;
   logic          status_wr, cycle_load;
   logic          fifo_empty, fifo_full;
   logic          push_vld, push_acc, pop_vld;
   logic [7:0]    count8;
   logic [31:0]   status_dat;
   logic          unused_addr_bits;

   assign ram_hit  = (addr[31:AW+2] == '0);
   assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
   assign unmapped = !ram_hit && !mmio_hit;
   assign ram_idx  = addr[AW+1:2];
   assign unused_addr_bits = ^addr[1:0];

   assign push_vld   = write_en && mmio_hit && (addr[3:2] == 2'd0) && byte_enable[0];
   assign status_wr  = write_en && mmio_hit && (addr[3:2] == 2'd1);
   assign cycle_load = write_en && mmio_hit && (addr[3:2] == 2'd2) && (byte_enable == 4'hF);

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign pop_vld    = !fifo_empty && console_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_acc   = push_vld && (!fifo_full || pop_vld);

   assign count8     = 8'(count_q);
   assign status_dat = {16'b0, count8, 5'b0, overflow_q, fifo_full, fifo_empty};

   always_comb begin
      read_data = '0;
      if (read_en && !rst) begin
         if (ram_hit) begin
            read_data = ram[ram_idx];
         end else if (mmio_hit) begin
            case (addr[3:2])
               2'd1:    read_data = status_dat;
               2'd2:    read_data = cycle_q;
               default: read_data = '0;
            endcase
         end
      end
   end

   // RAM has no reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (write_en && ram_hit) begin
         for (int k = 0; k < 4; k++) begin
            if (byte_enable[k]) ram[ram_idx][8*k +: 8] <= write_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) fifo_mem[wr_ptr] <= write_data[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         cycle_q     <= '0;
         bus_error_q <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + PW'(1);
         if (pop_vld)  rd_ptr <= rd_ptr + PW'(1);
         if (push_acc && !pop_vld)      count_q <= count_q + CW'(1);
         else if (!push_acc && pop_vld) count_q <= count_q - CW'(1);
         if (push_vld && !push_acc)           overflow_q <= 1'b1;
         else if (status_wr && write_data[2]) overflow_q <= 1'b0;
         cycle_q <= cycle_load ? write_data : cycle_q + 32'd1;
         if (unmapped && (read_en || write_en)) bus_error_q <= 1'b1;
      end
   end

   assign console_valid = !fifo_empty;
   assign console_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
   assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table for RAM/MMIO decode, scripted sequences for FIFO, counter and reset.
module tb_dmem_responder;
   localparam logic [31:0] TX     = 32'h0001_0000;
   localparam logic [31:0] STATUS = 32'h0001_0004;
   localparam logic [31:0] CYCLE  = 32'h0001_0008;
   localparam logic [31:0] RSV    = 32'h0001_000C;

   logic        clk, rst;
   logic [31:0] addr, write_data, read_data;
   logic        write_en, read_en, console_valid, console_ready, bus_error;
   logic [3:0]  byte_enable;
   logic [7:0]  console_data;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] con_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] wd;
      logic        we;
      logic        re;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[12];

   dmem_responder dut (
      .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
      .write_en(write_en), .read_en(read_en), .byte_enable(byte_enable),
      .read_data(read_data), .console_data(console_data),
      .console_valid(console_valid), .console_ready(console_ready),
      .bus_error(bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, sample 1ns later, score any console pop.
   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [3:0] be, input logic rdy);
      logic [7:0] exp_b;
      @(negedge clk);
      addr = a; write_data = wd; write_en = we; read_en = re;
      byte_enable = be; console_ready = rdy;
      #1;
      if (console_valid && console_ready) begin
         n_cmp++;
         if (con_q.size() == 0) begin
            n_err++;
            $display("FAIL console_unexpected: got %h, no byte expected", console_data);
         end else begin
            exp_b = con_q.pop_front();
            if (console_data !== exp_b) begin
               n_err++;
               $display("FAIL console_data: got %h expected %h", console_data, exp_b);
            end
         end
      end
   endtask

   task automatic idle(input logic rdy);
      step(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, rdy);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      step(a, d, 1'b1, 1'b0, be, 1'b0);
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      step(a, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0);
      check(name, read_data, exp);
   endtask

   task automatic push(input logic [7:0] b, input logic rdy);
      step(TX, {24'h0, b}, 1'b1, 1'b0, 4'b0001, rdy);
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      do begin
         idle(1'b1);
         k++;
      end while (console_valid && k < budget);
      check({name, "_bounded"}, 32'(k < budget), 32'd1);
      check({name, "_leftover"}, 32'(con_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; addr = '0; write_data = '0; write_en = 1'b0; read_en = 1'b0;
      byte_enable = '0; console_ready = 1'b0;

      vt[0]  = '{32'h10,   32'hDEAD_BEEF, 1'b1, 1'b0, 4'hF,    32'h0};
      vt[1]  = '{32'h10,   32'h0000_00AA, 1'b1, 1'b0, 4'b0001, 32'h0};
      vt[2]  = '{32'h10,   32'h0,         1'b0, 1'b1, 4'h0,    32'hDEAD_BEAA};
      vt[3]  = '{32'h13,   32'h0,         1'b0, 1'b1, 4'h0,    32'hDEAD_BEAA};
      vt[4]  = '{32'h10,   32'hFFFF_FFFF, 1'b1, 1'b0, 4'h0,    32'h0};
      vt[5]  = '{32'h10,   32'h0,         1'b0, 1'b0, 4'h0,    32'h0};
      vt[6]  = '{32'h14,   32'h1122_3344, 1'b1, 1'b0, 4'hF,    32'h0};
      vt[7]  = '{32'h14,   32'h5566_7788, 1'b1, 1'b1, 4'b1100, 32'h1122_3344};
      vt[8]  = '{32'h14,   32'h0,         1'b0, 1'b1, 4'h0,    32'h5566_3344};
      vt[9]  = '{32'hFFC,  32'hA5A5_A5A5, 1'b1, 1'b1, 4'hF,    32'h0};
      vt[10] = '{RSV,      32'h1234_5678, 1'b1, 1'b1, 4'hF,    32'h0};
      vt[11] = '{TX,       32'h0,         1'b0, 1'b1, 4'h0,    32'h0};
      // vt[9] reads an unwritten word alongside the store; patch its expectation after the loop instead.

      #12;
      check("rst_read_data", read_data, 32'h0);
      check("rst_console_valid", 32'(console_valid), 32'h0);
      check("rst_console_data", 32'(console_data), 32'h0);
      check("rst_bus_error", 32'(bus_error), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rd("status_after_reset", STATUS, 32'h0000_0001);

      for (int i = 0; i < 12; i++) begin
         step(vt[i].a, vt[i].wd, vt[i].we, vt[i].re, vt[i].be, 1'b0);
         if (i != 9) check($sformatf("vec%0d", i), read_data, vt[i].exp);
      end
      rd("ram_last_word", 32'hFFC, 32'hA5A5_A5A5);
      rd("reserved_read", RSV, 32'h0);
      check("no_bus_error_in_map", 32'(bus_error), 32'h0);

      // Two-byte push with consumer stalled, then drain.
      push(8'h48, 1'b0); con_q.push_back(8'h48);
      check("push_latency_valid", 32'(console_valid), 32'h0);
      push(8'h69, 1'b0); con_q.push_back(8'h69);
      check("head_after_push", 32'(console_data), 32'h48);
      rd("status_two", STATUS, 32'h0000_0200);
      check("head_stable", 32'(console_data), 32'h48);
      drain("drain_hi", 10);
      rd("status_drained", STATUS, 32'h0000_0001);

      // Overflow: ninth byte dropped.
      for (int i = 0; i < 9; i++) begin
         push(8'h30 + 8'(i), 1'b0);
         if (i < 8) con_q.push_back(8'h30 + 8'(i));
      end
      rd("status_overflow", STATUS, 32'h0000_0806);
      wr(STATUS, 32'h4, 4'hF);
      rd("status_ovf_cleared", STATUS, 32'h0000_0802);
      drain("drain_ovf", 20);

      // Full FIFO with simultaneous pop accepts the push.
      for (int i = 0; i < 8; i++) begin
         push(8'h40 + 8'(i), 1'b0);
         con_q.push_back(8'h40 + 8'(i));
      end
      con_q.push_back(8'h58);
      push(8'h58, 1'b1);
      rd("status_full_pop_push", STATUS, 32'h0000_0802);
      drain("drain_full_pop", 20);

      // Cycle counter load, wrap and partial-store rejection.
      wr(CYCLE, 32'hFFFF_FFFE, 4'hF);
      rd("cycle_0", CYCLE, 32'hFFFF_FFFE);
      rd("cycle_1", CYCLE, 32'hFFFF_FFFF);
      rd("cycle_2", CYCLE, 32'h0000_0000);
      step(CYCLE, 32'h1234_5678, 1'b1, 1'b1, 4'b0111, 1'b0);
      check("cycle_partial_pre", read_data, 32'h0000_0001);
      rd("cycle_partial_post", CYCLE, 32'h0000_0002);

      // Unmapped access makes bus_error stick.
      rd("unmapped_read", 32'h0002_0000, 32'h0);
      check("bus_error_not_yet", 32'(bus_error), 32'h0);
      idle(1'b0);
      check("bus_error_set", 32'(bus_error), 32'h1);
      idle(1'b0);
      check("bus_error_sticky", 32'(bus_error), 32'h1);

      // Asynchronous reset mid-cycle with bytes queued.
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      idle(1'b0);
      check("pre_reset_valid", 32'(console_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_bus_error", 32'(bus_error), 32'h0);
      check("arst_console_valid", 32'(console_valid), 32'h0);
      check("arst_console_data", 32'(console_data), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rd("status_after_arst", STATUS, 32'h0000_0001);
      rd("ram_survives_reset", 32'h10, 32'hDEAD_BEAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder on the CPU data-memory port: it answers the load/store requests issued by the core's MEM stage with a byte-enabled word RAM plus a small memory-mapped I/O window. The MMIO window holds a console transmit FIFO, drained through a valid/ready byte stream, and a free-running cycle counter. The block replaces the plain data memory beside the CPU top and uses the CPU's existing `mem_*` port semantics unchanged.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words; power of two.
- `MMIO_BASE`, 32'h0001_0000: base byte address of the MMIO window; 16-byte aligned.
- `FIFO_DEPTH`, 8: console FIFO entries; power of two, at least 2.

- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `addr`, in, 32: byte address from the CPU.
- `write_data`, in, 32: store data, already lane-aligned by the CPU.
- `write_en`, in, 1: store request this cycle.
- `read_en`, in, 1: load request this cycle.
- `byte_enable`, in, 4: lane mask; bit k covers `write_data[8k+7:8k]`.
- `read_data`, out, 32: load response.
- `console_data`, out, 8: byte at the FIFO head.
- `console_valid`, out, 1: FIFO is not empty.
- `console_ready`, in, 1: consumer accepts `console_data` this cycle.
- `bus_error`, out, 1: sticky flag for an access to an unmapped address.

## Operation
- Address decode uses `addr[31:2]`. `addr[1:0]` is ignored.
- RAM region: `addr < DEPTH_WORDS*4`.
  - Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
  - A store writes only the lanes whose `byte_enable` bit is set.
  - Reset does not clear RAM contents.
- MMIO region, offsets from `MMIO_BASE`:
  - +0x0 TX: a store with `byte_enable[0]=1` pushes `write_data[7:0]`. A read returns 0.
  - +0x4 STATUS: read value is `{16'b0, count[7:0], 5'b0, overflow, full, empty}`. A store with `write_data[2]=1` clears `overflow`.
  - +0x8 CYCLE: 32-bit counter, increments every cycle and wraps from 0xFFFF_FFFF to 0. A store with all four byte enables set loads `write_data`. Partial stores are ignored.
  - +0xC: reserved. Reads return 0. Stores are ignored and do not raise `bus_error`.
- Unmapped address: reads return 0, stores are ignored, and `bus_error` sets if `read_en` or `write_en` is high.
- `read_en` and `write_en` both high: the store is performed and `read_data` returns the pre-store value.
- `read_data` is 0 whenever `read_en` is low.
- Console FIFO:
  - A push while full is dropped and sets sticky `overflow`, unless a pop occurs in the same cycle. In that case the push is accepted.
  - A pop occurs when `console_valid && console_ready`.
  - A simultaneous push and pop on an empty FIFO is impossible, because `valid` is low. The push is accepted.
  - `count` ranges 0..FIFO_DEPTH; `full` means `count==FIFO_DEPTH`.

## Timing
- Reset values: `read_data` 0 (`read_en` is don't-care during reset), `console_valid` 0, `console_data` 0, `bus_error` 0. FIFO empty, `count` 0, `overflow` 0, CYCLE 0.
- Reset asserted mid-operation empties the FIFO immediately and drops any in-flight push. RAM is unaffected.
- Reads are combinational, zero latency: `read_data` is valid in the same cycle as `read_en`/`addr`, matching the CPU MEM stage.
- Stores commit at the rising edge that samples `write_en`. A read of the same word in the next cycle returns the new data.
- A pushed byte appears on `console_data`/`console_valid` one cycle after the push edge.
- `console_data` is stable while `console_valid && !console_ready`. It is driven from the FIFO head register, not from `write_data`.
- STATUS reflects register state before the current edge: a push and a STATUS read in the same cycle report the old count.
- CYCLE reads the pre-increment value. A load of CYCLE takes effect at the edge; the following cycle reads the loaded value plus 0, then it increments.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with `byte_enable`=4'b1111. Then write 0x000000AA with 4'b0001 to the same address. A read of 0x10 returns 0xDEADBEAA.
- Push 'H' (0x48) and 'i' (0x69) to MMIO_BASE+0x0 with `console_ready`=0. STATUS reads 0x0000_0200. Raise `console_ready`: 0x48 then 0x69 appear on consecutive cycles, then `console_valid` drops and STATUS reads 0x0000_0001.
- Push 9 bytes with `console_ready`=0 and FIFO_DEPTH=8. STATUS reads 0x0000_0806 (count 8, overflow, full). Write 0x4 to STATUS: the result is 0x0000_0802. The drain yields the first 8 bytes only.
- Hold FIFO full with `console_ready`=1 and push in the same cycle. `count` stays 8, `overflow` stays 0, and the pushed byte is drained last.
- Load CYCLE with 0xFFFF_FFFE, then read on each of the next 3 cycles: 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. A partial-enable store to CYCLE is ignored.
- Read 0x0002_0000: `read_data`=0 and `bus_error` rises on the next edge and stays high. Assert `rst` asynchronously mid-cycle: `bus_error`, `console_valid` and `count` clear immediately, and RAM word 0x10 keeps 0xDEADBEAA.
